// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch (IF) and the load/store unit (DM).
// Optional IF starvation guard is enabled by defining STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int MEM_LATENCY   = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [63:0]       dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_instr,
  output logic              mem_read_data,
  output logic              mem_write,
  output logic [63:0]       mem_write_data,
  input  logic [31:0]       mem_instr_in,
  input  logic [63:0]       mem_data_in,
  output logic              busy,
  output logic [1:0]        dbg_state
);

`ifdef STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  localparam int            CW         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
  localparam int            SW         = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  // Handshake: a requester holds req and stable fields until the 1-cycle gnt pulse;
  // the result arrives as a 1-cycle rvalid/done pulse MEM_LATENCY+1 cycles after gnt.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [SW-1:0]       streak;
  logic                owner_dm;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [63:0]         wdata_q;
  logic [31:0]         if_rdata_q;
  logic [63:0]         dm_rdata_q;
  logic                guard_fire;

  assign guard_fire = GUARD_EN && (streak == STREAK_MAX);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;

  always_comb begin
    state_nx       = state;
    if_gnt         = 1'b0;
    dm_gnt         = 1'b0;
    if_rvalid      = 1'b0;
    dm_done        = 1'b0;
    mem_addr       = '0;
    mem_read_instr = 1'b0;
    mem_read_data  = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    case (state)
      S_IDLE: begin
        // No grant while reset is asserted so every output reads 0 during reset.
        if (reset && (if_req || dm_req)) begin
          if (dm_req && !(if_req && guard_fire)) dm_gnt = 1'b1;
          else                                   if_gnt = 1'b1;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_addr       = addr_q;
        mem_read_instr = !owner_dm;
        mem_read_data  = owner_dm && !we_q;
        if (owner_dm && we_q) begin
          mem_write_data = wdata_q;
          mem_write      = (cnt == '0);
        end
        if (cnt == '0) state_nx = S_RESP;
      end
      S_RESP: begin
        if_rvalid = !owner_dm;
        dm_done   = owner_dm;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      streak     <= '0;
      owner_dm   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (if_gnt || dm_gnt) begin
        owner_dm <= dm_gnt;
        we_q     <= dm_gnt && dm_we;
        addr_q   <= dm_gnt ? dm_addr : if_addr;
        wdata_q  <= dm_gnt ? dm_wdata : '0;
        cnt      <= CNT_LOAD;
        if (GUARD_EN) begin
          if (dm_gnt && if_req) streak <= streak + SW'(1);
          else                  streak <= '0;
        end
      end
      if (state == S_ACCESS) begin
        if (cnt == '0) begin
          if (owner_dm) dm_rdata_q <= we_q ? 64'd0 : mem_data_in;
          else          if_rdata_q <= mem_instr_in;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: latency-1 instance for traffic, latency-3 instance for reset abort.
// Expected order in the starvation test follows STARVE_GUARD_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, reset_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a (MEM_LATENCY=1)
  logic        if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_done;
  logic [63:0] if_addr, dm_addr, dm_wdata, dm_rdata, mem_addr, mem_write_data, mem_data_in = '0;
  logic [31:0] if_rdata, mem_instr_in = '0;
  logic        mem_read_instr, mem_read_data, mem_write, busy;
  logic [1:0]  dbg_state;
  // instance b (MEM_LATENCY=3)
  logic        b_if_req, b_if_gnt, b_if_rvalid, b_dm_req, b_dm_we, b_dm_gnt, b_dm_done;
  logic [63:0] b_if_addr, b_dm_addr, b_dm_wdata, b_dm_rdata, b_mem_addr, b_mem_write_data, b_mem_data_in = '0;
  logic [31:0] b_if_rdata, b_mem_instr_in = '0;
  logic        b_mem_read_instr, b_mem_read_data, b_mem_write, b_busy;
  logic [1:0]  b_dbg_state;

  mem_port_arbiter #(.ADDR_W(64), .MEM_LATENCY(1), .MAX_DM_STREAK(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_read_instr(mem_read_instr), .mem_read_data(mem_read_data),
    .mem_write(mem_write), .mem_write_data(mem_write_data),
    .mem_instr_in(mem_instr_in), .mem_data_in(mem_data_in), .busy(busy), .dbg_state(dbg_state)
  );

  mem_port_arbiter #(.ADDR_W(64), .MEM_LATENCY(3), .MAX_DM_STREAK(4)) u_dut_b (
    .clk(clk), .reset(reset_b),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_done(b_dm_done), .dm_rdata(b_dm_rdata),
    .mem_addr(b_mem_addr), .mem_read_instr(b_mem_read_instr), .mem_read_data(b_mem_read_data),
    .mem_write(b_mem_write), .mem_write_data(b_mem_write_data),
    .mem_instr_in(b_mem_instr_in), .mem_data_in(b_mem_data_in), .busy(b_busy), .dbg_state(b_dbg_state)
  );

  // phys_mem is what the DUTs write; ref_mem is the bench's own model of memory contents.
  logic [7:0] phys_mem [logic [63:0]];
  logic [7:0] ref_mem  [logic [63:0]];

  function automatic logic [7:0] byte_at(input bit from_ref, input logic [63:0] a);
    if (from_ref) return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    return phys_mem.exists(a) ? phys_mem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] rd_be(input bit from_ref, input logic [63:0] a, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[55:0], byte_at(from_ref, a + 64'(i))};
    return v;
  endfunction

  int wr_pulses = 0, b_wr_pulses = 0;
  always @(negedge clk) begin
    logic [63:0] t;
    if (mem_write) begin
      wr_pulses++;
      for (int i = 0; i < 8; i++) phys_mem[mem_addr + 64'(i)] = mem_write_data[63-8*i -: 8];
    end
    if (b_mem_write) begin
      b_wr_pulses++;
      for (int i = 0; i < 8; i++) phys_mem[b_mem_addr + 64'(i)] = b_mem_write_data[63-8*i -: 8];
    end
    t = rd_be(0, mem_addr, 4);   mem_instr_in   = t[31:0];
    mem_data_in = rd_be(0, mem_addr, 8);
    t = rd_be(0, b_mem_addr, 4); b_mem_instr_in = t[31:0];
    b_mem_data_in = rd_be(0, b_mem_addr, 8);
  end

  int n_vec = 0, n_err = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // scoreboard: expectations pushed at grant, popped at rvalid/done
  logic [31:0] if_exp_q[$];
  logic [63:0] dm_exp_q[$];
  bit          grant_log[$];
  int          if_gnt_cyc, dm_gnt_cyc, if_rv_cyc, mri_cyc, b_done_cnt = 0;

  always @(negedge clk) begin
    if (reset && if_gnt) begin
      logic [63:0] t;
      t = rd_be(1, if_addr, 4);
      if_exp_q.push_back(t[31:0]);
      grant_log.push_back(1'b0);
      if_gnt_cyc = cyc;
    end
    if (reset && dm_gnt) begin
      if (dm_we) begin
        dm_exp_q.push_back(64'd0);
        for (int i = 0; i < 8; i++) ref_mem[dm_addr + 64'(i)] = dm_wdata[63-8*i -: 8];
      end else begin
        dm_exp_q.push_back(rd_be(1, dm_addr, 8));
      end
      grant_log.push_back(1'b1);
      dm_gnt_cyc = cyc;
    end
    if (mem_read_instr) mri_cyc = cyc;
    if (if_rvalid) begin
      if_rv_cyc = cyc;
      if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
      else                      check("if_rdata", if_rdata, if_exp_q.pop_front());
    end
    if (dm_done) begin
      if (dm_exp_q.size() == 0) check("dm_done_unexpected", 1, 0);
      else                      check("dm_rdata", dm_rdata, dm_exp_q.pop_front());
    end
    if (b_dm_done) b_done_cnt++;
  end

  task automatic do_if(input logic [63:0] a);
    bit seen = 0;
    if_req = 1'b1; if_addr = a;
    for (int i = 0; i < 64 && !seen; i++) begin @(negedge clk); seen = if_gnt; end
    if (!seen) check("if_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [63:0] a, input logic [63:0] d);
    bit seen = 0;
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = d;
    for (int i = 0; i < 64 && !seen; i++) begin @(negedge clk); seen = dm_gnt; end
    if (!seen) check("dm_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  task automatic wait_drain();
    int i = 0;
    do begin @(negedge clk); i++; end
    while ((busy || if_exp_q.size() != 0 || dm_exp_q.size() != 0) && i < 64);
    if (i >= 64) check("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  bit exp_order[6];
  int w0;
  bit seen_b;

  initial begin
    reset = 1'b0; reset_b = 1'b0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0; b_dm_addr = '0; b_dm_wdata = '0;
    begin
      logic [7:0] init_bytes[4];
      init_bytes = '{8'h8C, 8'h00, 8'h00, 8'h01};
      for (int i = 0; i < 4; i++) begin
        phys_mem[64'h2000 + 64'(i)] = init_bytes[i];
        ref_mem[64'h2000 + 64'(i)]  = init_bytes[i];
      end
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] r;
      r = 8'($urandom_range(0, 255));
      phys_mem[64'h4000 + 64'(i)] = r;
      ref_mem[64'h4000 + 64'(i)]  = r;
    end
    for (int i = 0; i < 8; i++) phys_mem[64'h3000 + 64'(i)] = 8'hA0 + 8'(i);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_if_gnt", if_gnt, 0);
    check("rst_dm_gnt", dm_gnt, 0);
    check("rst_if_rvalid", if_rvalid, 0);
    check("rst_dm_done", dm_done, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_ctl", {mem_read_instr, mem_read_data, mem_write}, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_b_busy", b_busy, 0);
    @(posedge clk); #1;
    reset = 1'b1; reset_b = 1'b1;

    // IF fetch, latency 1
    do_if(64'h2000);
    wait_drain();
    check("t1_gnt_to_mri", 64'(mri_cyc - if_gnt_cyc), 1);
    check("t1_gnt_to_rvalid", 64'(if_rv_cyc - if_gnt_cyc), 2);
    check("t1_if_rdata", if_rdata, 64'h8C000001);

    // store then load
    w0 = wr_pulses;
    do_dm(1'b1, 64'h10000, 64'h1122334455667788);
    wait_drain();
    check("t2_wr_pulses", 64'(wr_pulses - w0), 1);
    check("t2_phys_mem", rd_be(0, 64'h10000, 8), 64'h1122334455667788);
    do_dm(1'b0, 64'h10000, 64'd0);
    wait_drain();
    check("t2_load", dm_rdata, 64'h1122334455667788);
    check("t2_if_rdata_held", if_rdata, 64'h8C000001);

    // simultaneous requests
    grant_log.delete();
    fork
      do_dm(1'b0, 64'h10000, 64'd0);
      do_if(64'h2000);
    join
    wait_drain();
    check("t3_grants", grant_log.size(), 2);
    check("t3_first_dm", grant_log[0], 1);
    check("t3_second_if", grant_log[1], 0);
    check("t3_if_after_resp", 64'(if_gnt_cyc - dm_gnt_cyc), 3);

    // both requests held high
`ifdef STARVE_GUARD_EN
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    grant_log.delete();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10000;
    if_req = 1'b1; if_addr = 64'h2000;
    for (int i = 0; i < 200 && grant_log.size() < 6; i++) @(negedge clk);
    @(posedge clk); #1;
    dm_req = 1'b0; if_req = 1'b0;
    wait_drain();
    check("t5_grant_count", grant_log.size() >= 6, 1);
    for (int i = 0; i < 6; i++)
      check($sformatf("t5_order%0d", i), (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_order[i]);

    // random traffic
    for (int n = 0; n < 10; n++) begin
      logic [63:0] da, ia, wd;
      logic        we;
      da = 64'h4000 + 64'(8 * $urandom_range(0, 15));
      ia = 64'h4000 + 64'(4 * $urandom_range(0, 31));
      wd = {$urandom, $urandom};
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        fork
          do_dm(we, da, wd);
          do_if(ia);
        join
      end else begin
        do_dm(we, da, wd);
      end
      wait_drain();
    end

    // reset during a latency-3 store: strobe never reached
    b_dm_req = 1'b1; b_dm_we = 1'b1; b_dm_addr = 64'h3000; b_dm_wdata = 64'hDEADBEEFCAFEF00D;
    seen_b = 0;
    for (int i = 0; i < 64 && !seen_b; i++) begin @(negedge clk); seen_b = b_dm_gnt; end
    check("t4_b_gnt", seen_b, 1);
    @(posedge clk); #1;
    b_dm_req = 1'b0; reset_b = 1'b0;
    @(negedge clk);
    check("t4_in_access", b_dbg_state, 1);
    @(negedge clk);
    check("t4_busy", b_busy, 0);
    check("t4_state", b_dbg_state, 0);
    check("t4_mem_ctl", {b_mem_read_instr, b_mem_read_data, b_mem_write, b_dm_done}, 0);
    check("t4_mem_addr", b_mem_addr, 0);
    check("t4_mem_wdata", b_mem_write_data, 0);
    @(posedge clk); #1;
    reset_b = 1'b1;
    repeat (8) @(negedge clk);
    check("t4_no_done", b_done_cnt, 0);
    check("t4_no_write", b_wr_pulses, 0);
    check("t4_mem_intact", rd_be(0, 64'h3000, 8), 64'hA0A1A2A3A4A5A6A7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
